// File: rtl/gray_to_color_stream.sv
// gray_to_color_stream: expands 8-bit gray pixels into 24-bit {b,g,r} color
// pixels. The output side has a 2-entry buffer, and each buffered pixel is
// tagged with start-of-frame and end-of-line flags taken from raster position
// counters that advance on every input transfer.
// Optional feature: define GRAY_TO_COLOR_SEPIA_EN to replace plain channel
// replication with a sepia tint.
module gray_to_color_stream #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = 10,
    parameter int YW     = 9
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_gray_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [23:0] out_color_o,
    output logic        out_sof_o,
    output logic        out_eol_o,
    output logic        frame_done_o
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef struct packed {
        logic [23:0] color;
        logic        sof;
        logic        eol;
    } entry_t;

    entry_t          mem_q [2];
    logic            wr_ptr_q, rd_ptr_q;
    logic [1:0]      count_q, count_d;
    logic            rdy_en_q;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            frame_done_q, frame_done_d;
    logic            push, pop;
    logic [23:0]     color_map;
    entry_t          head;

    // Ready depends only on registered state, so it never combinationally
    // follows out_ready. rdy_en_q keeps it low until the first clock after reset.
    assign in_ready_o  = rdy_en_q & (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign head        = mem_q[rd_ptr_q];

    // Outputs are driven to zero while the buffer is empty.
    always_comb begin
        out_color_o = 24'd0;
        out_sof_o   = 1'b0;
        out_eol_o   = 1'b0;
        if (out_valid_o) begin
            out_color_o = head.color;
            out_sof_o   = head.sof;
            out_eol_o   = head.eol;
        end
    end
    assign frame_done_o = frame_done_q;

    // Gray-to-color mapping, evaluated on the incoming pixel so it adds no latency.
`ifdef GRAY_TO_COLOR_SEPIA_EN
    logic [9:0] r_wide;
    logic [7:0] r_sep, b_sep;
    always_comb begin
        r_wide    = {2'b00, in_gray_i} + {5'b00000, in_gray_i[7:3]} + 10'd16;
        r_sep     = (r_wide > 10'd255) ? 8'hFF : r_wide[7:0];
        b_sep     = in_gray_i - {2'b00, in_gray_i[7:2]};
        color_map = {b_sep, in_gray_i, r_sep};
    end
`else
    always_comb begin
        color_map = {in_gray_i, in_gray_i, in_gray_i};
    end
`endif

    // Next-state for occupancy, raster position and frame-done pulse.
    always_comb begin
        count_d      = count_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (push) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d          = '0;
                    frame_done_d = 1'b1;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Buffer storage, pointers and control state; reset discards buffered pixels.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            rdy_en_q     <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            rdy_en_q     <= 1'b1;
            count_q      <= count_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            if (push) begin
                mem_q[wr_ptr_q] <= '{color: color_map,
                                     sof:   (x_q == '0) && (y_q == '0),
                                     eol:   (x_q == X_LAST)};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

endmodule

// File: tb/tb_gray_to_color_stream.sv
// Self-checking bench for gray_to_color_stream with a small 4x2 frame.
module tb_gray_to_color_stream;

    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_gray;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_color;
    logic        out_sof;
    logic        out_eol;
    logic        frame_done;

    always #5 clk = ~clk;

    gray_to_color_stream #(.WIDTH(W), .HEIGHT(H), .XW(2), .YW(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_gray_i(in_gray),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_color_o(out_color), .out_sof_o(out_sof), .out_eol_o(out_eol),
        .frame_done_o(frame_done)
    );

    typedef struct {
        logic [23:0] color;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0, n_fail = 0;
    int          pix_idx, n_acc;
    bit          rdy_en, fd_exp, prev_stall, accepted;
    logic [23:0] prev_color;
    int          sof_seen, eol_seen, fd_seen, out_cnt;

    // Reference colour mapping from the channel rules, in plain integer math.
    function automatic logic [23:0] map_color(input logic [7:0] g);
`ifdef GRAY_TO_COLOR_SEPIA_EN
        int r, b;
        r = int'(g) + int'(g) / 8 + 16;
        if (r > 255) r = 255;
        b = int'(g) - int'(g) / 4;
        return {8'(b), g, 8'(r)};
`else
        return {g, g, g};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, check outputs, update the model.
    task automatic step(input bit v, input logic [7:0] g, input bit r);
        int pos;
        @(negedge clk);
        in_valid  = v;
        in_gray   = g;
        out_ready = r;
        #1;
        accepted = 0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_en && q.size() < 2});
        chk("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
        if (frame_done) fd_seen++;
        if (prev_stall) chk("stall_hold", {8'd0, out_color}, {8'd0, prev_color});
        if (out_valid && q.size() != 0) begin
            chk("out_color", {8'd0, out_color}, {8'd0, q[0].color});
            chk("out_sof", {31'd0, out_sof}, {31'd0, q[0].sof});
            chk("out_eol", {31'd0, out_eol}, {31'd0, q[0].eol});
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (out_sof) sof_seen++;
            if (out_eol) eol_seen++;
            if (q.size() != 0) void'(q.pop_front());
        end
        prev_stall = out_valid && !out_ready;
        prev_color = out_color;
        fd_exp = 0;
        if (in_valid && in_ready) begin
            pos = pix_idx % (W * H);
            q.push_back('{map_color(g), pos == 0, (pos % W) == W - 1});
            fd_exp = (pos == W * H - 1);
            pix_idx++;
            n_acc++;
            accepted = 1;
        end
        rdy_en = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_color", {8'd0, out_color}, 32'd0);
        chk("rst_flags", {29'd0, out_sof, out_eol, frame_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd0);
        q.delete();
        pix_idx    = 0;
        fd_exp     = 0;
        prev_stall = 0;
        rdy_en     = 1;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 1'b0; in_gray = 8'd0; out_ready = 1'b0;
        sof_seen = 0; eol_seen = 0; fd_seen = 0; out_cnt = 0; n_acc = 0;

        // Single pixel latency and colour mapping corner values.
        do_reset();
        step(1, 8'h80, 1);
        step(1, 8'hF0, 1);
`ifdef GRAY_TO_COLOR_SEPIA_EN
        chk("color_80", {8'd0, out_color}, 32'h006080A0);
`else
        chk("color_80", {8'd0, out_color}, 32'h00808080);
`endif
        chk("first_sof", {30'd0, out_sof, out_eol}, 32'd2);
        step(1, 8'h00, 1);
`ifdef GRAY_TO_COLOR_SEPIA_EN
        chk("color_F0", {8'd0, out_color}, 32'h00B4F0FF);
`else
        chk("color_F0", {8'd0, out_color}, 32'h00F0F0F0);
`endif
        step(0, 8'h00, 1);
`ifdef GRAY_TO_COLOR_SEPIA_EN
        chk("color_00", {8'd0, out_color}, 32'h00000010);
`else
        chk("color_00", {8'd0, out_color}, 32'h00000000);
`endif
        step(0, 8'h00, 1);

        // Backpressure: buffer fills after two pixels, nothing lost on release.
        do_reset();
        base = out_cnt;
        step(1, 8'h01, 0);
        step(1, 8'h02, 0);
        step(1, 8'h03, 0);
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_not_taken", {31'd0, accepted}, 32'd0);
        for (int i = 0; i < 10 && !accepted; i++) step(1, 8'h03, 1);
        chk("bp_third_taken", {31'd0, accepted}, 32'd1);
        repeat (4) step(0, 8'h00, 1);
        chk("bp_out_count", out_cnt - base, 32'd3);

        // Full 4x2 frame back to back, then the first pixel of the next frame.
        do_reset();
        sof_seen = 0; eol_seen = 0; fd_seen = 0; base = out_cnt;
        for (int i = 0; i < W * H; i++) step(1, 8'($urandom), 1);
        repeat (2) step(0, 8'h00, 1);
        chk("frame_outputs", out_cnt - base, W * H);
        chk("frame_sof_cnt", sof_seen, 32'd1);
        chk("frame_eol_cnt", eol_seen, 32'd2);
        chk("frame_done_cnt", fd_seen, 32'd1);
        step(1, 8'h42, 1);
        step(0, 8'h00, 1);
        chk("next_frame_sof", sof_seen, 32'd2);

        // Random valid/ready toggling over 1000 pixels.
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 20000 && n_acc < 1000; i++)
            step(($urandom % 3) != 0, 8'($urandom), ($urandom % 3) != 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) step(0, 8'h00, 1);
        chk("rand_accepted", n_acc, 32'd1000);
        chk("rand_drained", q.size(), 32'd0);

        // Asynchronous reset mid-line with two buffered pixels.
        do_reset();
        step(1, 8'h05, 1);
        step(1, 8'h06, 0);
        step(1, 8'h07, 0);
        step(0, 8'h00, 0);
        chk("mid_buffered", {31'd0, out_valid}, 32'd1);
        do_reset();
        step(1, 8'h09, 1);
        step(0, 8'h00, 1);
        chk("post_rst_sof", {31'd0, out_sof}, 32'd1);
        step(0, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
